// File: rtl/lc3_mem_seq_if.sv
// Word-wide memory port with byte lanes and a ready handshake.
// The sequencer is the master; the memory model or controller is the slave.
interface lc3_mem_seq_if;
  logic        en;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  wmask;
  logic        ready;
  logic [15:0] rdata;

  modport master (
    output en, we, addr, wdata, wmask,
    input  ready, rdata
  );

  modport slave (
    input  en, we, addr, wdata, wmask,
    output ready, rdata
  );
endinterface

// File: rtl/lc3_mem_seq.sv
// LC-3b memory-class sequencer: LDW, LDB, STW, STB, LEA.
// Drives EA selects, latches MAR, runs the memory handshake, issues writeback.
module lc3_mem_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_addr1_sel,
  output logic [1:0]  o_addr2_sel,
  output logic        o_lshf1,
  output logic [10:0] o_ir_slice,
  input  logic [15:0] i_ea_in,
  output logic [2:0]  o_base_raddr,
  output logic [2:0]  o_src_raddr,
  input  logic [15:0] i_src_data,
  lc3_mem_seq_if.master mem,
  output logic        o_reg_we,
  output logic [2:0]  o_reg_dr,
  output logic [15:0] o_reg_wdata,
  output logic        o_set_cc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EA,
    S_MEM,
    S_WB,
    S_FIN
  } state_t;

  localparam logic [15:0] LP_TO_LAST =
    (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_ir;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic [15:0] r_cnt;
  logic        r_err;

  logic [3:0]  w_op;
  logic        w_lea;
  logic        w_word;
  logic        w_byte;
  logic        w_store;
  logic        w_load;
  logic        w_busy;
  logic        w_to;
  logic        w_unaligned;
  logic [7:0]  w_byte_rd;

  function automatic logic f_valid(input logic [3:0] op);
    return op inside {4'b0010, 4'b0011, 4'b0110,
                      4'b0111, 4'b1110};
  endfunction

  assign w_op    = r_ir[15:12];
  assign w_lea   = (w_op == 4'b1110);
  assign w_word  = (w_op == 4'b0110) || (w_op == 4'b0111);
  assign w_byte  = (w_op == 4'b0010) || (w_op == 4'b0011);
  assign w_store = (w_word || w_byte) && w_op[0];
  assign w_load  = (w_word || w_byte) && !w_op[0];
  assign w_busy  = (r_state != S_IDLE);

  // TIMEOUT of zero means wait for ready forever.
  assign w_to = (TIMEOUT != 0) && (r_cnt == LP_TO_LAST);

  assign w_unaligned = w_word && i_ea_in[0];
  assign w_byte_rd   = r_mar[0] ? r_mdr[15:8] : r_mdr[7:0];

  assign o_busy       = w_busy;
  assign o_ir_slice   = w_busy ? r_ir[10:0] : 11'd0;
  assign o_base_raddr = w_busy ? r_ir[8:6]  : 3'd0;
  assign o_src_raddr  = w_busy ? r_ir[11:9] : 3'd0;

  always_comb begin
    w_nxt       = r_state;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_addr1_sel = 1'b0;
    o_addr2_sel = 2'd0;
    o_lshf1     = 1'b0;
    mem.en      = 1'b0;
    mem.we      = 1'b0;
    mem.addr    = 16'd0;
    mem.wdata   = 16'd0;
    mem.wmask   = 2'b00;
    o_reg_we    = 1'b0;
    o_reg_dr    = 3'd0;
    o_reg_wdata = 16'd0;
    o_set_cc    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nxt = f_valid(i_ir[15:12]) ? S_EA : S_FIN;
        end
      end

      S_EA: begin
        unique case (1'b1)
          w_lea: begin
            o_addr2_sel = 2'd2;
            o_lshf1     = 1'b1;
          end
          w_word: begin
            o_addr1_sel = 1'b1;
            o_addr2_sel = 2'd1;
            o_lshf1     = 1'b1;
          end
          w_byte: begin
            o_addr1_sel = 1'b1;
            o_addr2_sel = 2'd1;
          end
          default: ;
        endcase
        if (w_lea) begin
          w_nxt = S_WB;
        end else if (w_unaligned) begin
          w_nxt = S_FIN;
        end else begin
          w_nxt = S_MEM;
        end
      end

      S_MEM: begin
        mem.en   = 1'b1;
        mem.addr = {r_mar[15:1], 1'b0};
        if (w_store) begin
          mem.we = 1'b1;
          if (w_word) begin
            mem.wdata = i_src_data;
            mem.wmask = 2'b11;
          end else begin
            mem.wdata = {i_src_data[7:0], i_src_data[7:0]};
            mem.wmask = r_mar[0] ? 2'b10 : 2'b01;
          end
        end
        if (mem.ready) begin
          w_nxt = w_load ? S_WB : S_FIN;
        end else if (w_to) begin
          w_nxt = S_FIN;
        end
      end

      S_WB: begin
        o_done   = 1'b1;
        o_reg_we = 1'b1;
        o_reg_dr = r_ir[11:9];
        if (w_lea) begin
          o_reg_wdata = r_mar;
        end else if (w_word) begin
          o_reg_wdata = r_mdr;
          o_set_cc    = 1'b1;
        end else begin
          o_reg_wdata = {{8{w_byte_rd[7]}}, w_byte_rd};
          o_set_cc    = 1'b1;
        end
        w_nxt = S_IDLE;
      end

      S_FIN: begin
        o_done = 1'b1;
        o_err  = r_err;
        w_nxt  = S_IDLE;
      end

      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ir    <= 16'd0;
      r_mar   <= 16'd0;
      r_mdr   <= 16'd0;
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_ir  <= i_ir;
        r_err <= !f_valid(i_ir[15:12]);
      end
      if (r_state == S_EA) begin
        r_mar <= i_ea_in;
        r_err <= w_unaligned;
      end
      if (r_state == S_MEM && mem.ready) begin
        r_mdr <= mem.rdata;
      end
      if (r_state == S_MEM && !mem.ready && w_to) begin
        r_err <= 1'b1;
      end
      // Counts consecutive MEM cycles without ready.
      if (r_state == S_MEM && !mem.ready) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= 16'd0;
      end
    end
  end

endmodule
